// File: rtl/pe_pkg.sv
// Shared definitions for the PE input-splitter sequencer.
//   seq_state_t : sequencer FSM states
//   FILT_ROWS   : filter rows loaded per job (rows tagged 1..FILT_ROWS)
//   IFMAP_BITS  : bits in one 5x5 binary ifmap window
//   loc_width() : conv-location field width, i.e. the packet bits left over
//                 once the ifmap window occupies the MSBs
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_FILT = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } seq_state_t;

  localparam int FILT_ROWS  = 5;
  localparam int IFMAP_BITS = 25;

  function automatic int loc_width(input int fw);
    return 5 * fw - IFMAP_BITS;
  endfunction

endpackage

// File: rtl/pe_out_reg.sv
// Single-stage valid/ready pipeline register.
//   clk, rst           : clock, async active-high reset
//   in_valid/in_data   : load request; only taken while in_ready is high
//   in_ready           : register is empty or is being emptied this cycle
//   out_valid/out_data : registered packet, held stable while stalled
//   out_ready          : downstream accepts
// A load and a downstream handshake may coincide, giving 1 packet/cycle.
module pe_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_split_sequencer.sv
// Feeds the PE input splitter. Per job: five filter-row packets tagged
// rows 1..5 (skipped on filter reuse), then NUM_LOC ifmap packets carrying
// {ifmap window, conv location}. One valid/ready output channel, registered.
//   clk, rst                      : clock, async active-high reset
//   start, reuse_filter           : job request (sampled in IDLE only)
//   filt_valid/filt_ready/filt_data : filter-row source
//   ifm_valid/ifm_ready/ifm_data  : ifmap-window source
//   out_valid/out_ready/out_data  : packet to splitter
//   out_ifmapb_filter             : 1 = filter packet, 0 = ifmap packet
//   out_filter_row                : 1..5 for filter packets, 0 otherwise
//   busy                          : not IDLE
//   done                          : one-cycle pulse at job completion
module pe_split_sequencer
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int NUM_LOC      = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      reuse_filter,
  input  logic                      filt_valid,
  output logic                      filt_ready,
  input  logic [5*FILTER_WIDTH-1:0] filt_data,
  input  logic                      ifm_valid,
  output logic                      ifm_ready,
  input  logic [IFMAP_BITS-1:0]     ifm_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5*FILTER_WIDTH-1:0] out_data,
  output logic                      out_ifmapb_filter,
  output logic [2:0]                out_filter_row,
  output logic                      busy,
  output logic                      done
);

  localparam int PW    = 5 * FILTER_WIDTH;
  localparam int LOC_W = loc_width(FILTER_WIDTH);
  // register payload: {ifmapb_filter, filter_row[2:0], data}
  localparam int RW    = PW + 4;

  seq_state_t        state, state_nxt;
  logic [2:0]        row_cnt, row_cnt_nxt;
  logic [LOC_W-1:0]  loc_cnt, loc_cnt_nxt;
  logic              space;
  logic              filt_hs, ifm_hs;
  logic              ld_valid;
  logic [RW-1:0]     ld_pkt, reg_pkt;

  // Readies follow register space so a source is only taken when the
  // packet can be stored this cycle.
  assign filt_ready = (state == LOAD_FILT) && space;
  assign ifm_ready  = (state == STREAM) && space;
  assign filt_hs    = filt_valid && filt_ready;
  assign ifm_hs     = ifm_valid && ifm_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= 3'd1;
      loc_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      loc_cnt <= loc_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    loc_cnt_nxt = loc_cnt;
    ld_valid    = 1'b0;
    ld_pkt      = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          row_cnt_nxt = 3'd1;
          loc_cnt_nxt = '0;
          state_nxt   = reuse_filter ? STREAM : LOAD_FILT;
        end
      end
      LOAD_FILT: begin
        if (filt_hs) begin
          ld_valid = 1'b1;
          ld_pkt   = {1'b1, row_cnt, filt_data};
          if (row_cnt == 3'(FILT_ROWS)) begin
            row_cnt_nxt = 3'd1;
            state_nxt   = STREAM;
          end else begin
            row_cnt_nxt = row_cnt + 3'd1;
          end
        end
      end
      STREAM: begin
        if (ifm_hs) begin
          ld_valid = 1'b1;
          ld_pkt   = {1'b0, 3'd0, ifm_data, loc_cnt};
          if (loc_cnt == LOC_W'(NUM_LOC - 1)) begin
            loc_cnt_nxt = '0;
            state_nxt   = DRAIN;
          end else begin
            loc_cnt_nxt = loc_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        // job ends once the last packet is gone or leaves this cycle
        if (space) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  pe_out_reg #(.W(RW)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ld_valid),
    .in_data   (ld_pkt),
    .in_ready  (space),
    .out_valid (out_valid),
    .out_data  (reg_pkt),
    .out_ready (out_ready)
  );

  assign out_data          = reg_pkt[PW-1:0];
  assign out_filter_row    = reg_pkt[PW+2:PW];
  assign out_ifmapb_filter = reg_pkt[PW+3];

endmodule

// File: tb/tb_pe_split_sequencer.sv
module tb_pe_split_sequencer;

  localparam int FW    = 8;
  localparam int NL    = 25;
  localparam int PW    = 5 * FW;
  localparam int LOC_W = 5 * FW - 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 0, start1 = 0, reuse_filter = 0;
  logic          filt_valid = 0, ifm_valid = 0, out_ready = 0;
  logic [PW-1:0] filt_data = '0;
  logic [24:0]   ifm_data = '0;
  logic          filt_ready, ifm_ready, out_valid, out_ifmapb_filter, busy, done;
  logic [PW-1:0] out_data;
  logic [2:0]    out_filter_row;
  logic          u1_filt_ready, u1_ifm_ready, u1_out_valid, u1_ifb, u1_busy, u1_done;
  logic [PW-1:0] u1_out_data;
  logic [2:0]    u1_row;

  pe_split_sequencer #(.FILTER_WIDTH(FW), .NUM_LOC(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_filter(reuse_filter),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ifmapb_filter(out_ifmapb_filter), .out_filter_row(out_filter_row),
    .busy(busy), .done(done));

  // second instance for the single-location boundary
  pe_split_sequencer #(.FILTER_WIDTH(FW), .NUM_LOC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .reuse_filter(reuse_filter),
    .filt_valid(filt_valid), .filt_ready(u1_filt_ready), .filt_data(filt_data),
    .ifm_valid(ifm_valid), .ifm_ready(u1_ifm_ready), .ifm_data(ifm_data),
    .out_valid(u1_out_valid), .out_ready(out_ready), .out_data(u1_out_data),
    .out_ifmapb_filter(u1_ifb), .out_filter_row(u1_row),
    .busy(u1_busy), .done(u1_done));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PW-1:0] data;
    logic          ifb;
    logic [2:0]    row;
  } pkt_t;
  pkt_t exp_q[$];

  // mode: 0 clean, 1 out_ready 1,0,0,1, 2 filter gap after row 2, 3 random
  // Every task starts and ends just after a rising edge.
  task automatic run_job(input string name, input bit reuse, input int mode,
                         input bit extra_start, input bit abort10, input int post);
    logic [PW-1:0] fdat[5];
    logic [24:0]   idat[NL];
    logic [PW-1:0] held = '0;
    bit   stalled = 0, fin = 0, saw_fr = 0;
    int   fi = 0, ii = 0, cyc = 0, run = 0, maxrun = 0, gap = 0;
    pkt_t e;
    exp_q.delete();
    for (int r = 0; r < 5; r++) fdat[r] = PW'({$urandom(), $urandom()});
    for (int k = 0; k < NL; k++) idat[k] = (mode == 1) ? 25'h1ABCDEF : 25'($urandom());
    if (!reuse)
      for (int r = 0; r < 5; r++) begin
        e.data = fdat[r]; e.ifb = 1'b1; e.row = 3'(r + 1); exp_q.push_back(e);
      end
    for (int k = 0; k < NL; k++) begin
      e.data = {idat[k], LOC_W'(k)}; e.ifb = 1'b0; e.row = 3'd0; exp_q.push_back(e);
    end
    start = 1; reuse_filter = reuse; filt_valid = 0; ifm_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    while (!fin && cyc < 600) begin
      filt_valid = (fi < 5) && !(mode == 2 && fi == 2 && gap < 3) &&
                   (mode != 3 || $urandom_range(0, 3) != 0);
      filt_data  = (fi < 5) ? fdat[fi] : '0;
      ifm_valid  = (ii < NL) && (mode != 3 || $urandom_range(0, 3) != 0);
      ifm_data   = (ii < NL) ? idat[ii] : '0;
      out_ready  = (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) :
                   (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = extra_start && (ii >= 5) && (ii < 8);
      @(negedge clk);
      if (abort10 && ii == 10) begin
        filt_valid = 0; ifm_valid = 0; start = 0;
        rst = 1; #1;
        checks++;
        if ({out_valid, busy, done, filt_ready, ifm_ready} !== 5'b0) begin
          errors++;
          $display("FAIL %s mid_reset: valid/busy/done/fr/ir=%b want 00000", name,
                   {out_valid, busy, done, filt_ready, ifm_ready});
        end
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      if (filt_ready) saw_fr = 1;
      checks++;
      if (filt_ready && ifm_ready) begin
        errors++; $display("FAIL %s both_ready: fr=1 ir=1 want not both", name);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL %s busy_active: got %b want 1", name, busy);
      end
      if (out_valid && out_ifmapb_filter) begin
        checks++;
        if (out_filter_row == 0 || out_filter_row > 5) begin
          errors++; $display("FAIL %s row_range: got %0d want 1..5", name, out_filter_row);
        end
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL %s hold: got v=%b data=%h want v=1 data=%h", name, out_valid, out_data, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (ifm_ready !== 1'b0) begin
          errors++; $display("FAIL %s stall_ready: ifm_ready=%b want 0", name, ifm_ready);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid) begin run++; if (run > maxrun) maxrun = run; end else run = 0;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_pkt: got data=%h want none", name, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_ifmapb_filter !== e.ifb || out_filter_row !== e.row) begin
            errors++;
            $display("FAIL %s pkt: got data=%h ifb=%b row=%0d want data=%h ifb=%b row=%0d",
                     name, out_data, out_ifmapb_filter, out_filter_row, e.data, e.ifb, e.row);
          end
        end
      end
      if (done) begin
        fin = 1;
        checks++;
        if (exp_q.size() != 0 || ii != NL) begin
          errors++;
          $display("FAIL %s done_early: pending=%0d inputs=%0d want 0 and %0d", name,
                   exp_q.size(), ii, NL);
        end
      end
      if (mode == 2 && fi == 2 && !filt_valid) gap++;
      if (filt_valid && filt_ready) fi++;
      if (ifm_valid && ifm_ready) ii++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout: no done after %0d cycles, want done", name, cyc);
    end
    if (reuse) begin
      checks++;
      if (saw_fr) begin errors++; $display("FAIL %s reuse_filt_ready: got 1 want 0", name); end
    end
    if (mode == 0 && !reuse) begin
      checks++;
      if (maxrun != 30) begin
        errors++; $display("FAIL %s throughput: run=%0d want 30", name, maxrun);
      end
    end
    filt_valid = 0; ifm_valid = 0; out_ready = 1;
    for (int p = 0; p < post; p++) begin
      @(negedge clk);
      checks++;
      if ({done, busy, out_valid} !== 3'b0) begin
        errors++;
        $display("FAIL %s after_done: done/busy/valid=%b want 000", name, {done, busy, out_valid});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    #12;
    checks++;
    if ({out_valid, done, busy, filt_ready, ifm_ready, out_ifmapb_filter} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {out_valid, done, busy, filt_ready, ifm_ready, out_ifmapb_filter});
    end
    checks++;
    if (out_data !== '0 || out_filter_row !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%h row=%0d want 0 0", out_data, out_filter_row);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();        run_job("basic", 0, 0, 0, 0, 3); endtask
  task automatic test_reuse();        run_job("reuse", 1, 0, 0, 0, 3); endtask
  task automatic test_backpressure(); run_job("backpressure", 0, 1, 0, 0, 3); endtask
  task automatic test_source_gaps();  run_job("gaps", 0, 2, 0, 0, 3); endtask
  task automatic test_start_busy();   run_job("start_busy", 0, 0, 1, 0, 5); endtask

  task automatic test_reset_mid();
    run_job("reset_mid", 0, 0, 0, 1, 0);
    run_job("after_reset", 0, 0, 0, 0, 2);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 0, 0, 0, 0, 0);
    run_job("b2b_b", 1, 0, 0, 0, 0);
    run_job("b2b_c", 0, 0, 0, 0, 2);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) run_job("random", 1'($urandom_range(0, 1)), 3, 0, 0, 1);
  endtask

  task automatic test_num_loc1();
    logic [24:0] d;
    int npkt = 0, ndone = 0;
    d = 25'($urandom());
    start1 = 1; reuse_filter = 1; ifm_valid = 1; ifm_data = d; out_ready = 1;
    @(posedge clk); #1;
    start1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (u1_out_valid && out_ready) begin
        npkt++;
        checks++;
        if (u1_out_data !== {d, LOC_W'(0)} || u1_ifb !== 1'b0 || u1_row !== 3'd0) begin
          errors++;
          $display("FAIL loc1_pkt: got data=%h ifb=%b row=%0d want data=%h ifb=0 row=0",
                   u1_out_data, u1_ifb, u1_row, {d, LOC_W'(0)});
        end
      end
      if (u1_done) ndone++;
      @(posedge clk); #1;
    end
    ifm_valid = 0;
    checks++;
    if (npkt != 1 || ndone != 1) begin
      errors++; $display("FAIL loc1_count: pkts=%0d dones=%0d want 1 1", npkt, ndone);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reuse();
    test_backpressure();
    test_source_gaps();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_num_loc1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_split_sequencer.md
Name: pe_split_sequencer

Overview:
- Clocked controller that feeds the PE input splitter, which routes packets to five filter-row buffers or to the ifmap/conv-location path.
- Per job: issues five filter-row packets tagged rows 1..5 (skipped when filters are reused), then NUM_LOC ifmap packets with an internally generated conv location.
- Drives the splitter's data, ifmapb_filter and filter_row fields as one valid/ready output channel, and signals job completion.

Parameters:
FILTER_WIDTH, 8, bits per filter element; packet width is 5*FILTER_WIDTH; must be >= 6
NUM_LOC, 25, ifmap packets (conv locations) per job; 1 <= NUM_LOC <= 2**LOC_W
LOC_W, derived 5*FILTER_WIDTH-25 (15 at default), conv_loc field width; localparam, not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle job request; sampled only in IDLE
reuse_filter  in  1  sampled with start; 1 = skip filter load
filt_valid  in  1  filter-row source valid
filt_ready  out  1  filter-row source ready
filt_data  in  5*FILTER_WIDTH  one filter row (5 elements)
ifm_valid  in  1  ifmap source valid
ifm_ready  out  1  ifmap source ready
ifm_data  in  25  one 5x5 ifmap window, 1 bit per pixel
out_valid  out  1  packet valid to splitter
out_ready  in  1  splitter accepts
out_data  out  5*FILTER_WIDTH  packet payload
out_ifmapb_filter  out  1  0 = ifmap packet, 1 = filter packet
out_filter_row  out  3  1..5 for filter packets, 0 for ifmap packets
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job completes

Behaviour:
- Reset (async assert, sync deassert handled externally): state IDLE; row_cnt=1; loc_cnt=0; out_valid, out_data, out_ifmapb_filter, out_filter_row, done = 0. All ready outputs are 0 in IDLE.
- Output register: single stage. space = !out_valid || out_ready.
  - out_* fields are held stable while out_valid && !out_ready.
  - A load into the register and a downstream handshake can occur in the same cycle (full throughput, 1 packet/cycle).
- Latency: input handshake at edge N -> out_valid at edge N (registered); earliest acceptance by splitter is edge N+1.
- IDLE: start=1 -> row_cnt=1, loc_cnt=0.
  - reuse_filter=0 -> LOAD_FILT.
  - reuse_filter=1 -> STREAM.
  - start outside IDLE is ignored, with no error.
- LOAD_FILT: filt_ready=space; ifm_ready=0.
  - On filt handshake: out_data=filt_data, out_ifmapb_filter=1, out_filter_row=row_cnt, out_valid=1; row_cnt++.
  - Handshake with row_cnt==5 -> STREAM, row_cnt returns to 1.
- STREAM: ifm_ready=space; filt_ready=0.
  - On ifm handshake: out_data={ifm_data, loc_cnt[LOC_W-1:0]} (ifmap in MSBs, location in LSBs); out_ifmapb_filter=0; out_filter_row=0; loc_cnt++.
  - Handshake with loc_cnt==NUM_LOC-1 -> DRAIN, loc_cnt=0.
- DRAIN: no readys. When out_valid==0, or out_valid && out_ready this cycle: done=1 for one cycle -> IDLE.
- busy=1 in LOAD_FILT, STREAM and DRAIN.
- Invariants:
  - out_filter_row is never 0 and never 6/7 when out_ifmapb_filter=1.
  - filt_ready and ifm_ready are never both 1.
- Boundaries:
  - NUM_LOC=1: STREAM accepts exactly one packet.
  - Back-to-back jobs: start may arrive in the cycle after done; no bubble required beyond that.
  - out_ready held low: sequencer stalls with no loss or duplication, and sources are back-pressured.
  - Reset mid-job: output packet is dropped, counters clear, done does not pulse.

Decomposition:
- Shared package pe_pkg: typedef enum {IDLE, LOAD_FILT, STREAM, DRAIN} seq_state_t; constants FILT_ROWS=5, IFMAP_BITS=25; function loc_width(fw)=5*fw-25.
- One sub-module: pe_out_reg (valid/ready pipeline register, parameterised width), reused for the output stage.
- FSM and counters stay in the top module.

Test Plan:
- Basic job: reset, start(reuse=0), sources always valid, out_ready=1 -> 5 filter packets with rows 1,2,3,4,5 and ifmapb=1, then 25 ifmap packets with conv_loc 0..24 and ifmapb=0; done pulses once; 30 consecutive cycles with out_valid=1.
- Filter reuse: start(reuse=1) -> first packet ifmap with conv_loc=0; filt_ready stays 0 for the whole job.
- Backpressure: out_ready toggles 1,0,0,1 pattern; ifm_data=25'h1ABCDEF -> out_data held stable while stalled; every input appears exactly once, in order; ifm_ready=0 whenever the register is full and not draining.
- Source gaps: filt_valid low for 3 cycles between rows 2 and 3 -> row tags stay contiguous 1..5; no spurious out_valid.
- Start while busy: second start during STREAM -> ignored; one done only.
- Reset mid-STREAM at loc 10: assert rst -> out_valid=0, busy=0, done=0 immediately; new job restarts at row 1 / loc 0.
